// File: rtl/wb_master_if_if.sv
// Wishbone B3 classic bus bundle between the CPU bridge (master) and a slave.
interface wb_master_if_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0]   wishbone_addr;
    logic [DATA_W-1:0]   wishbone_wdata;
    logic [DATA_W-1:0]   wishbone_rdata;
    logic                wishbone_we;
    logic [DATA_W/8-1:0] wishbone_sel;
    logic                wishbone_stb;
    logic                wishbone_cyc;
    logic                wishbone_ack;

    modport master (
        output wishbone_addr, wishbone_wdata, wishbone_we, wishbone_sel,
        output wishbone_stb, wishbone_cyc,
        input  wishbone_rdata, wishbone_ack
    );

    modport slave (
        input  wishbone_addr, wishbone_wdata, wishbone_we, wishbone_sel,
        input  wishbone_stb, wishbone_cyc,
        output wishbone_rdata, wishbone_ack
    );
endinterface

// File: rtl/wb_master_if.sv
// CPU-side Wishbone B3 classic master bridge: one request -> one bus cycle, stalls pipe until ack.
// Optional ack timeout in BUSY is enabled by defining WB_TIMEOUT_EN.
module wb_master_if #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned STALL_W     = 6,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [STALL_W-1:0]  i_stall,
    input  logic                i_flush,
    input  logic                i_cpu_ce,
    input  logic [DATA_W-1:0]   i_cpu_data,
    input  logic [ADDR_W-1:0]   i_cpu_addr,
    input  logic                i_cpu_we,
    input  logic [DATA_W/8-1:0] i_cpu_sel,
    output logic [DATA_W-1:0]   o_cpu_data,
    output logic                o_stallreq,
    wb_master_if_if.master      wb
);

    typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic                we;
        logic [DATA_W/8-1:0] sel;
        logic                stb;
        logic                cyc;
    } bus_t;

    state_e            state_q, state_d;
    bus_t              bus_q, bus_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              stalled;
    logic              timeout;

    assign stalled = |i_stall;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires on the TIMEOUT_CYC-th BUSY cycle without ack.
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        rbuf_d     = rbuf_q;
        o_stallreq = 1'b0;
        o_cpu_data = '0;
`ifdef WB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_cpu_ce && !i_flush) begin
                    bus_d.addr = i_cpu_addr;
                    bus_d.data = i_cpu_data;
                    bus_d.we   = i_cpu_we;
                    bus_d.sel  = i_cpu_sel;
                    bus_d.stb  = 1'b1;
                    bus_d.cyc  = 1'b1;
                    rbuf_d     = '0;
                    o_stallreq = 1'b1;
                    state_d    = StBusy;
`ifdef WB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StBusy: begin
                // Ack wins over flush: the completed transfer is delivered.
                if (wb.wishbone_ack) begin
                    bus_d = '0;
                    if (!bus_q.we) begin
                        rbuf_d     = wb.wishbone_rdata;
                        o_cpu_data = wb.wishbone_rdata;
                    end
                    state_d = stalled ? StWaitStall : StIdle;
                end else if (timeout) begin
                    bus_d   = '0;
                    rbuf_d  = '0;
                    state_d = StIdle;
                end else if (i_flush) begin
                    bus_d      = '0;
                    rbuf_d     = '0;
                    o_stallreq = 1'b1;
                    state_d    = StIdle;
                end else begin
                    o_stallreq = 1'b1;
`ifdef WB_TIMEOUT_EN
                    cnt_d      = cnt_q + 1'b1;
`endif
                end
            end
            StWaitStall: begin
                // Hold read data until the rest of the pipeline is ready to take it.
                o_cpu_data = rbuf_q;
                if (!stalled) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (i_rst) begin
            o_stallreq = 1'b0;
            o_cpu_data = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            bus_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            rbuf_q  <= rbuf_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign wb.wishbone_addr  = bus_q.addr;
    assign wb.wishbone_wdata = bus_q.data;
    assign wb.wishbone_we    = bus_q.we;
    assign wb.wishbone_sel   = bus_q.sel;
    assign wb.wishbone_stb   = bus_q.stb;
    assign wb.wishbone_cyc   = bus_q.cyc;

endmodule

// File: tb/tb_wb_master_if.sv
// Self-checking bench for wb_master_if; the bench plays the Wishbone slave (mem[a] = a).
module tb_wb_master_if;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned STALL_W     = 6;
    localparam int unsigned TIMEOUT_CYC = 255;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [STALL_W-1:0]  i_stall;
    logic                i_flush;
    logic                i_cpu_ce;
    logic [DATA_W-1:0]   i_cpu_data;
    logic [ADDR_W-1:0]   i_cpu_addr;
    logic                i_cpu_we;
    logic [DATA_W/8-1:0] i_cpu_sel;
    logic [DATA_W-1:0]   o_cpu_data;
    logic                o_stallreq;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    wb_master_if_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    wb_master_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_stall(i_stall),
        .i_flush(i_flush),
        .i_cpu_ce(i_cpu_ce),
        .i_cpu_data(i_cpu_data),
        .i_cpu_addr(i_cpu_addr),
        .i_cpu_we(i_cpu_we),
        .i_cpu_sel(i_cpu_sel),
        .o_cpu_data(o_cpu_data),
        .o_stallreq(o_stallreq),
        .wb(wb)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic check_bus_idle(input string tag);
        check_eq({tag, "_cyc"}, wb.wishbone_cyc, 0);
        check_eq({tag, "_stb"}, wb.wishbone_stb, 0);
        check_eq({tag, "_we"}, wb.wishbone_we, 0);
        check_eq({tag, "_addr"}, wb.wishbone_addr, 0);
        check_eq({tag, "_data"}, wb.wishbone_wdata, 0);
        check_eq({tag, "_sel"}, wb.wishbone_sel, 0);
    endtask

    task automatic check_bus_busy(input logic we, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] sel);
        check_eq("busy_cyc", wb.wishbone_cyc, 1);
        check_eq("busy_stb", wb.wishbone_stb, 1);
        check_eq("busy_we", wb.wishbone_we, we);
        check_eq("busy_addr", wb.wishbone_addr, addr);
        check_eq("busy_data", wb.wishbone_wdata, data);
        check_eq("busy_sel", wb.wishbone_sel, sel);
    endtask

    // One complete transfer; reads push the slave's value for addr onto the scoreboard.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input int waits, input logic [5:0] stall,
                        input logic flush_on_ack);
        logic [31:0] exp_rd;
        exp_rd     = '0;
        i_cpu_ce   = 1'b1;
        i_cpu_we   = we;
        i_cpu_addr = addr;
        i_cpu_data = data;
        i_cpu_sel  = sel;
        i_stall    = stall;
        if (!we) exp_q.push_back(addr);
        smp();
        check_eq("req_stallreq", o_stallreq, 1);
        check_eq("req_cpu_data", o_cpu_data, 0);
        check_eq("req_cyc", wb.wishbone_cyc, 0);
        tick();
        i_cpu_ce   = 1'b0;
        i_cpu_addr = '1;
        i_cpu_data = '1;
        i_cpu_sel  = '0;
        for (int k = 0; k < waits; k++) begin
            smp();
            check_eq("wait_stallreq", o_stallreq, 1);
            check_eq("wait_cpu_data", o_cpu_data, 0);
            check_bus_busy(we, addr, data, sel);
            tick();
        end
        wb.wishbone_ack   = 1'b1;
        wb.wishbone_rdata = wb.wishbone_addr;
        i_flush           = flush_on_ack;
        smp();
        check_bus_busy(we, addr, data, sel);
        check_eq("ack_stallreq", o_stallreq, 0);
        if (!we) begin
            check_eq("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
        end
        check_eq("ack_cpu_data", o_cpu_data, exp_rd);
        tick();
        wb.wishbone_ack   = 1'b0;
        wb.wishbone_rdata = 32'hDEAD_BEEF;
        i_flush           = 1'b0;
        smp();
        check_bus_idle("post_ack");
        check_eq("post_stallreq", o_stallreq, 0);
        if (stall != 0) begin
            check_eq("hold_cpu_data", o_cpu_data, exp_rd);
            tick();
            // A new request while parked must be ignored.
            i_cpu_ce   = 1'b1;
            i_cpu_we   = 1'b0;
            i_cpu_addr = 32'h55;
            smp();
            check_eq("hold2_cpu_data", o_cpu_data, exp_rd);
            check_eq("hold2_stallreq", o_stallreq, 0);
            tick();
            i_cpu_ce = 1'b0;
            i_stall  = '0;
            smp();
            check_eq("ignored_ce_cyc", wb.wishbone_cyc, 0);
            check_eq("release_cpu_data", o_cpu_data, exp_rd);
            tick();
            smp();
            check_eq("idle_cpu_data", o_cpu_data, 0);
            check_eq("idle_stallreq", o_stallreq, 0);
            check_eq("idle_cyc", wb.wishbone_cyc, 0);
        end else begin
            check_eq("idle_cpu_data", o_cpu_data, 0);
        end
        tick();
    endtask

    task automatic start_read(input logic [31:0] addr);
        i_cpu_ce   = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = addr;
        i_cpu_data = 32'h0;
        i_cpu_sel  = 4'hF;
        tick();
        i_cpu_ce = 1'b0;
    endtask

    task automatic flush_busy(input int busy_cycles);
        start_read(32'h1234);
        for (int k = 0; k < busy_cycles; k++) begin
            smp();
            check_eq("fl_wait_stallreq", o_stallreq, 1);
            tick();
        end
        i_flush = 1'b1;
        smp();
        check_eq("fl_cyc_before", wb.wishbone_cyc, 1);
        tick();
        i_flush = 1'b0;
        smp();
        check_bus_idle("flushed");
        check_eq("flushed_stallreq", o_stallreq, 0);
        check_eq("flushed_cpu_data", o_cpu_data, 0);
        tick();
    endtask

    task automatic reset_busy();
        start_read(32'h4444);
        smp();
        check_eq("rb_cyc_before", wb.wishbone_cyc, 1);
        tick();
        i_rst = 1'b1;
        smp();
        check_eq("rb_stallreq_in_rst", o_stallreq, 0);
        check_eq("rb_cpu_data_in_rst", o_cpu_data, 0);
        tick();
        i_rst = 1'b0;
        smp();
        check_bus_idle("rb_after");
        check_eq("rb_stallreq", o_stallreq, 0);
        tick();
    endtask

    task automatic idle_ce_flush();
        i_cpu_ce   = 1'b1;
        i_flush    = 1'b1;
        i_cpu_addr = 32'h77;
        smp();
        check_eq("cf_stallreq", o_stallreq, 0);
        tick();
        i_cpu_ce = 1'b0;
        i_flush  = 1'b0;
        smp();
        check_eq("cf_cyc", wb.wishbone_cyc, 0);
        tick();
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic timeout_abort();
        int cnt;
        cnt = 0;
        start_read(32'h9999);
        for (int k = 0; k < int'(TIMEOUT_CYC) + 8; k++) begin
            smp();
            if (!o_stallreq) break;
            cnt++;
            tick();
        end
        check_eq("to_cycles", cnt, TIMEOUT_CYC - 1);
        check_eq("to_cpu_data", o_cpu_data, 0);
        tick();
        smp();
        check_bus_idle("to_after");
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic        rw;
        i_rst             = 1'b1;
        i_stall           = '0;
        i_flush           = 1'b0;
        i_cpu_ce          = 1'b0;
        i_cpu_data        = '0;
        i_cpu_addr        = '0;
        i_cpu_we          = 1'b0;
        i_cpu_sel         = '0;
        wb.wishbone_ack   = 1'b0;
        wb.wishbone_rdata = '0;
        tick();
        tick();
        smp();
        check_bus_idle("reset");
        check_eq("reset_stallreq", o_stallreq, 0);
        check_eq("reset_cpu_data", o_cpu_data, 0);
        tick();
        i_rst = 1'b0;

        xfer(1'b0, 32'hEE, 32'h0, 4'hF, 0, 6'h01, 1'b0);
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 0, 6'h00, 1'b0);
        xfer(1'b1, 32'h200, 32'hFF, 4'b0011, 0, 6'h00, 1'b0);
        xfer(1'b1, 32'h204, 32'hAB, 4'b1100, 2, 6'h02, 1'b0);
        xfer(1'b0, 32'h3C, 32'h0, 4'hF, 5, 6'h00, 1'b0);
        flush_busy(0);
        flush_busy(2);
        xfer(1'b0, 32'hCAFE_0008, 32'h0, 4'hF, 1, 6'h20, 1'b1);
        idle_ce_flush();
        reset_busy();
`ifdef WB_TIMEOUT_EN
        timeout_abort();
`else
        xfer(1'b0, 32'h600D_0000, 32'h0, 4'hF, int'(TIMEOUT_CYC) + 5, 6'h00, 1'b0);
`endif
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rw = 1'($urandom_range(0, 1));
            xfer(rw, ra, $urandom(), 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                 6'($urandom_range(0, 1)), 1'b0);
        end

        check_eq("sb_final_depth", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
